encoder_8_to_3_seq: RTL
=======================

// Module: encoder_8_to_3_seq
// PURPOSE
// Sequential 8-to-3 encoder: the inverse direction of the 3-to-8 one-hot decoder.
// - Accepts an 8-bit request vector (any number of bits set) over a valid/ready handshake.
// - Emits the 3-bit index of every set bit, lowest index first, one per output handshake.
// - Marks the final index with 'last'.
// - Turns multi-hot status/request words back into a stream of binary indices for downstream select logic.
// PARAMETERS
// W        8   request vector width; fixed at 8 for this block (index width 3)
// ZERO_EMIT 1  1: an all-zero vector produces one beat with out_zero=1; 0: it is silently dropped
// PORTS
// clk        input   1  single clock, rising edge
// rst_n      input   1  asynchronous, active-low reset
// in_valid   input   1  request vector valid
// in_ready   output  1  block can accept a vector
// in_req     input   8  request vector, bit i set = index i pending
// out_valid  output  1  idx/last/out_zero valid
// out_ready  input   1  downstream accepts the current beat
// idx        output  3  binary index of the lowest still-pending bit
// last       output  1  current beat is the final beat for this vector
// out_zero   output  1  beat represents an all-zero vector (idx=0, last=1)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, pend=8'h00.
//   Outputs during/after reset: in_ready=1, out_valid=0, idx=0, last=0, out_zero=0.
// - States:
//   - IDLE: in_ready=1, out_valid=0.
//     - in_valid & in_req!=0: pend<=in_req, go to EMIT.
//     - in_valid & in_req==0, ZERO_EMIT=1: go to ZERO.
//     - in_valid & in_req==0, ZERO_EMIT=0: vector consumed, stay in IDLE.
//   - EMIT: in_ready=0, out_valid=1.
//     - idx = position of lowest set bit of pend.
//     - last = (pend has exactly one bit set).
//     - out_valid & out_ready: clear bit idx in pend; if last, go to IDLE.
//   - ZERO: in_ready=0, out_valid=1, idx=0, last=1, out_zero=1.
//     - out_ready: go to IDLE.
// - Latency: first beat is valid in the cycle after the input handshake. Outputs are decoded from registered pend only.
// - Throughput:
//   - One index per cycle while out_ready=1.
//   - A vector with k bits set occupies k EMIT cycles plus 1 IDLE cycle before the next accept.
//   - No overlap between consecutive vectors.
// - Backpressure: while out_valid=1 and out_ready=0, idx/last/out_zero and pend hold stable; out_valid never drops without a handshake.
// - in_ready depends on state only (no combinational path from out_ready or in_valid).
// - in_req is sampled only on the in_valid & in_ready edge; later changes to in_req have no effect.
// - Order is strictly ascending index: e.g. 8'b1000_0001 emits 0 then 7; 8'hFF emits 0..7 with last on 7.
// - Reset mid-operation: pending bits are discarded; out_valid=0 and in_ready=1 immediately (asynchronous).
// - No X on outputs in any state. Illegal state encodings recover to IDLE.
// TESTING
// 1. Reset, then in_req=8'b0010_0100, out_ready=1
//    -> beats idx=2 (last=0), idx=5 (last=1) on consecutive cycles; in_ready=1 on the next cycle.
// 2. in_req=8'hFF, out_ready=1
//    -> idx=0..7 on 8 consecutive cycles; last only with idx=7; in_ready held 0 throughout.
// 3. in_req=8'b1000_0000, out_ready held 0 for 5 cycles, then 1
//    -> idx=7, last=1 held stable for all 5 stall cycles, then accepted; back to IDLE.
// 4. in_req=8'h00
//    -> ZERO_EMIT=1: one beat with out_zero=1, idx=0, last=1.
//    -> ZERO_EMIT=0: no beat; in_ready stays 1.
// 5. in_req=8'b0101_0001; assert rst_n=0 after the first beat (idx=0) is accepted
//    -> out_valid=0 and in_ready=1 asynchronously.
//    -> after release, new in_req=8'b0000_0010 emits only idx=1 with last=1.
// 6. Change in_req while in EMIT (after accepting 8'b0000_0011)
//    -> emitted stream is still idx=0, idx=1; the new value is ignored.

Source files
------------

// File: rtl/encoder_8_to_3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot request vector and streams out
// the index of every set bit, lowest first, with 'last' on the final index.
module encoder_8_to_3_seq #(
    parameter int W         = 8,
    parameter bit ZERO_EMIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(W)-1:0] idx,
    output logic                 last,
    output logic                 out_zero
);

    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   pend, pend_nxt;

    function automatic logic [IW-1:0] lowest_idx(input logic [W-1:0] v);
        lowest_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IW'(i);
        end
    endfunction

    function automatic logic one_hot_or_zero(input logic [W-1:0] v);
        one_hot_or_zero = ((v & (v - W'(1))) == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        idx       = '0;
        last      = 1'b0;
        out_zero  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_req != '0) begin
                        pend_nxt  = in_req;
                        state_nxt = EMIT;
                    end else if (ZERO_EMIT) begin
                        state_nxt = ZERO;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                idx       = lowest_idx(pend);
                last      = one_hot_or_zero(pend);
                if (out_ready) begin
                    pend_nxt = pend & ~(W'(1) << idx);
                    if (last) state_nxt = IDLE;
                end
            end
            ZERO: begin
                out_valid = 1'b1;
                last      = 1'b1;
                out_zero  = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                // Unused encoding: refuse input for one cycle and fall back to IDLE.
                state_nxt = IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

endmodule
